// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: CPU request/response bundle plus the single-port SRAM port of ram_ctrl.
// master drives requests and read data; slave is the controller.
interface ram_ctrl_if #(parameter int ADDR_W = 14);
  logic              iren;
  logic              dren;
  logic [3:0]        dwen;
  logic [31:0]       iaddr;
  logic [31:0]       daddr;
  logic [31:0]       dstore;
  logic              iwait;
  logic              dwait;
  logic [31:0]       iload;
  logic [31:0]       dload;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  modport master (
    output iren, dren, dwen, iaddr, daddr, dstore, ram_rdata,
    input  iwait, dwait, iload, dload, ram_en, ram_we, ram_addr, ram_wdata
  );
  modport slave (
    input  iren, dren, dwen, iaddr, daddr, dstore, ram_rdata,
    output iwait, dwait, iload, dload, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl: arbitrates CPU fetch and data accesses onto one single-port SRAM with fixed read latency.
// Optional RAM_CTRL_FAIR_ARB_EN: after two data grants that kept iren waiting, the next grant goes to the fetch.
module ram_ctrl #(
  parameter int ADDR_W      = 14,
  parameter int RAM_LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  ram_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam logic [1:0] LAT_M1 = 2'(RAM_LATENCY - 1);
  state_t            state_q, state_d;
  logic              gnt_i_q, gnt_i_d;
  logic              rd_q, rd_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              ram_en_q, ram_en_d;
  logic [3:0]        ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic [31:0]       iload_q, iload_d, dload_q, dload_d;
  logic              d_req, wr_req, pick_i, done_rd, unused_addr;
  assign d_req  = bus.dren | (|bus.dwen);
  assign wr_req = |bus.dwen;
  assign unused_addr = ^{bus.iaddr[31:ADDR_W+2], bus.iaddr[1:0], bus.daddr[31:ADDR_W+2], bus.daddr[1:0]};
`ifdef RAM_CTRL_FAIR_ARB_EN
  logic [1:0] fair_q, fair_d;
  assign pick_i = bus.iren & (!d_req | (fair_q == 2'd2));
  always_comb begin
    fair_d = fair_q;
    if (state_q == IDLE && pick_i) fair_d = 2'd0;
    else if (state_q == IDLE && d_req && bus.iren) fair_d = fair_q + 2'd1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) fair_q <= 2'd0;
    else fair_q <= fair_d;
`else
  assign pick_i = bus.iren & !d_req;
`endif
  always_comb begin
    state_d     = state_q;
    gnt_i_d     = gnt_i_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 4'd0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      IDLE: if (pick_i || d_req) begin
        state_d     = (!pick_i && wr_req) ? WRITE : READ;
        gnt_i_d     = pick_i;
        rd_d        = pick_i || !wr_req;
        cnt_d       = LAT_M1;
        ram_en_d    = 1'b1;
        ram_we_d    = pick_i ? 4'd0 : bus.dwen;
        ram_addr_d  = pick_i ? bus.iaddr[ADDR_W+1:2] : bus.daddr[ADDR_W+1:2];
        ram_wdata_d = (!pick_i && wr_req) ? bus.dstore : ram_wdata_q;
      end
      READ: begin
        cnt_d   = (cnt_q == 2'd0) ? cnt_q : cnt_q - 2'd1;
        state_d = (cnt_q == 2'd0) ? DONE : READ;
      end
      WRITE: state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end
  // Read data is valid during DONE, so it is forwarded straight out and also captured for holding.
  assign done_rd = (state_q == DONE) && rd_q;
  assign iload_d = (done_rd && gnt_i_q) ? bus.ram_rdata : iload_q;
  assign dload_d = (done_rd && !gnt_i_q) ? bus.ram_rdata : dload_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q     <= IDLE;
      gnt_i_q     <= 1'b0;
      rd_q        <= 1'b0;
      cnt_q       <= 2'd0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'd0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'd0;
      iload_q     <= 32'd0;
      dload_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      gnt_i_q     <= gnt_i_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      iload_q     <= iload_d;
      dload_q     <= dload_d;
    end
  assign bus.iwait     = !(state_q == DONE && gnt_i_q);
  assign bus.dwait     = !(state_q == DONE && !gnt_i_q);
  assign bus.iload     = iload_d;
  assign bus.dload     = dload_d;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: scoreboard bench for ram_ctrl at read latencies 1..4, each instance with its own SRAM model.
module tb_ram_ctrl;
  localparam int AW = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]    iren_s = 4'd0, dren_s = 4'd0;
  logic [3:0]    dwen_s [4];
  logic [31:0]   iaddr_s [4], daddr_s [4], dstore_s [4];
  logic [3:0]    iwait_w, dwait_w, ram_en_w;
  logic [31:0]   iload_w [4], dload_w [4], ram_wdata_w [4];
  logic [3:0]    ram_we_w [4];
  logic [AW-1:0] ram_addr_w [4];

  function automatic logic [31:0] init_word(int g, int i);
    return (i == 16) ? 32'h0050_0093 : {4'(g + 1), 12'h000, 16'(i)};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_inst
    ram_ctrl_if #(.ADDR_W(AW)) bus ();
    logic [31:0] mem [1 << AW];
    logic [31:0] pipe [4];
    ram_ctrl #(.ADDR_W(AW), .RAM_LATENCY(g + 1)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
    assign bus.iren      = iren_s[g];
    assign bus.dren      = dren_s[g];
    assign bus.dwen      = dwen_s[g];
    assign bus.iaddr     = iaddr_s[g];
    assign bus.daddr     = daddr_s[g];
    assign bus.dstore    = dstore_s[g];
    assign bus.ram_rdata = pipe[g];
    assign iwait_w[g]     = bus.iwait;
    assign dwait_w[g]     = bus.dwait;
    assign iload_w[g]     = bus.iload;
    assign dload_w[g]     = bus.dload;
    assign ram_en_w[g]    = bus.ram_en;
    assign ram_we_w[g]    = bus.ram_we;
    assign ram_addr_w[g]  = bus.ram_addr;
    assign ram_wdata_w[g] = bus.ram_wdata;
    initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(g, i);
      for (int s = 0; s < 4; s++) pipe[s] <= 32'd0;
    end
    always @(posedge clk) begin
      if (bus.ram_en) begin
        pipe[0] <= mem[bus.ram_addr];
        for (int b = 0; b < 4; b++)
          if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
      for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
    end
  end

  typedef struct { int inst; bit is_i; bit rd; logic [31:0] data; int cyc; } done_t;
  typedef struct { int inst; logic [AW-1:0] addr; logic [3:0] we; logic [31:0] wdata; int cyc; } acc_t;
  done_t dq[$];
  acc_t  aq[$];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input bit ok, input string nm, input string msg);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", nm, msg);
  endtask

  task automatic exp_done(input int k, input bit is_i, input bit rd, input logic [31:0] d, input int c);
    done_t e;
    e.inst = k; e.is_i = is_i; e.rd = rd; e.data = d; e.cyc = c;
    dq.push_back(e);
  endtask

  task automatic exp_acc(input int k, input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] wd, input int c);
    acc_t e;
    e.inst = k; e.addr = a; e.we = we; e.wdata = wd; e.cyc = c;
    aq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  done_t de;
  acc_t  ae;
  bit    mok;
  logic [31:0] got;
  always @(negedge clk) begin
    if (rst_n) for (int k = 0; k < 4; k++) begin
      if (!iwait_w[k] || !dwait_w[k]) begin
        mok = dq.size() != 0;
        if (mok) de = dq.pop_front();
        got = iwait_w[k] ? dload_w[k] : iload_w[k];
        mok = mok && de.inst == k && de.is_i == !iwait_w[k] && iwait_w[k] != dwait_w[k]
              && de.cyc == cyc && (!de.rd || got == de.data);
        chk(mok, "done", $sformatf("inst %0d iwait %0b dwait %0b cyc %0d data %h; expected inst %0d iport %0b cyc %0d data %h (queued %0d)",
            k, iwait_w[k], dwait_w[k], cyc, got, de.inst, de.is_i, de.cyc, de.data, dq.size()));
      end
      if (ram_en_w[k]) begin
        mok = aq.size() != 0;
        if (mok) ae = aq.pop_front();
        mok = mok && ae.inst == k && ae.addr == ram_addr_w[k] && ae.we == ram_we_w[k]
              && (ae.we == 4'd0 || ae.wdata == ram_wdata_w[k]) && ae.cyc == cyc;
        chk(mok, "ram_access", $sformatf("inst %0d addr %h we %b wdata %h cyc %0d; expected inst %0d addr %h we %b wdata %h cyc %0d (queued %0d)",
            k, ram_addr_w[k], ram_we_w[k], ram_wdata_w[k], cyc, ae.inst, ae.addr, ae.we, ae.wdata, ae.cyc, aq.size()));
      end
    end
  end

  initial begin
    int c, t0;
    bit ii;
    for (int k = 0; k < 4; k++) begin
      dwen_s[k] = 4'd0; iaddr_s[k] = 32'd0; daddr_s[k] = 32'd0; dstore_s[k] = 32'd0;
    end
    tick(1);
    chk(iwait_w[0] && dwait_w[0], "reset_wait", $sformatf("iwait %0b dwait %0b, expected 1 1", iwait_w[0], dwait_w[0]));
    chk(iload_w[0] == 32'd0 && dload_w[0] == 32'd0, "reset_load", $sformatf("iload %h dload %h, expected 0 0", iload_w[0], dload_w[0]));
    chk(!ram_en_w[0] && ram_we_w[0] == 4'd0 && ram_addr_w[0] == '0 && ram_wdata_w[0] == 32'd0, "reset_ram",
        $sformatf("en %0b we %b addr %h wdata %h, expected all 0", ram_en_w[0], ram_we_w[0], ram_addr_w[0], ram_wdata_w[0]));
    tick(1);
    #2 rst_n = 1'b1;
    tick(2);
    // fetch: upper address bits and byte offset are ignored, word 0x10
    c = cyc; iren_s[0] = 1'b1; iaddr_s[0] = 32'hFFFF_0042;
    exp_acc(0, 10'h010, 4'd0, 32'd0, c + 1);
    exp_done(0, 1'b1, 1'b1, 32'h0050_0093, c + 2);
    tick(1); iren_s[0] = 1'b0; tick(3);
    // byte write then read back through an unaligned address
    c = cyc; dwen_s[0] = 4'b0010; daddr_s[0] = 32'h104; dstore_s[0] = 32'h0000_AB00;
    exp_acc(0, 10'h041, 4'b0010, 32'h0000_AB00, c + 1);
    exp_done(0, 1'b0, 1'b0, 32'd0, c + 2);
    tick(1); dwen_s[0] = 4'd0; tick(3);
    c = cyc; dren_s[0] = 1'b1; daddr_s[0] = 32'h107;
    exp_acc(0, 10'h041, 4'd0, 32'd0, c + 1);
    exp_done(0, 1'b0, 1'b1, 32'h1000_AB41, c + 2);
    tick(1); dren_s[0] = 1'b0; tick(3);
    // dren with dwen is a write; inputs changed after grant must not matter
    c = cyc; dren_s[0] = 1'b1; dwen_s[0] = 4'hF; daddr_s[0] = 32'h84; dstore_s[0] = 32'hDEAD_BEEF;
    exp_acc(0, 10'h021, 4'hF, 32'hDEAD_BEEF, c + 1);
    exp_done(0, 1'b0, 1'b0, 32'd0, c + 2);
    tick(1); dren_s[0] = 1'b0; dwen_s[0] = 4'd0; daddr_s[0] = 32'd0; dstore_s[0] = 32'd0; tick(3);
    c = cyc; dren_s[0] = 1'b1; daddr_s[0] = 32'h84;
    exp_acc(0, 10'h021, 4'd0, 32'd0, c + 1);
    exp_done(0, 1'b0, 1'b1, 32'hDEAD_BEEF, c + 2);
    tick(1); dren_s[0] = 1'b0; tick(3);
    // simultaneous: data first, fetch completes RAM_LATENCY+2 cycles later
    c = cyc; iren_s[0] = 1'b1; iaddr_s[0] = 32'h40; dren_s[0] = 1'b1; daddr_s[0] = 32'h80;
    exp_acc(0, 10'h020, 4'd0, 32'd0, c + 1);
    exp_done(0, 1'b0, 1'b1, 32'h1000_0020, c + 2);
    exp_acc(0, 10'h010, 4'd0, 32'd0, c + 4);
    exp_done(0, 1'b1, 1'b1, 32'h0050_0093, c + 5);
    tick(1); dren_s[0] = 1'b0; tick(3); iren_s[0] = 1'b0; tick(3);
    // latency sweep 1..4
    for (int k = 0; k < 4; k++) begin
      c = cyc; dren_s[k] = 1'b1; daddr_s[k] = 32'h80;
      exp_acc(k, 10'h020, 4'd0, 32'd0, c + 1);
      exp_done(k, 1'b0, 1'b1, {4'(k + 1), 12'h000, 16'h0020}, c + k + 2);
      tick(1); dren_s[k] = 1'b0; tick(k + 4);
    end
    // continuous data stream with a pending fetch
    c = cyc; dren_s[0] = 1'b1; iren_s[0] = 1'b1; daddr_s[0] = 32'h80; iaddr_s[0] = 32'h40;
    for (int j = 0; j < 7; j++) begin
      ii = (j == 6);
`ifdef RAM_CTRL_FAIR_ARB_EN
      ii = ii || (j % 3 == 2);
`endif
      t0 = (j == 6) ? c + 18 : c + 3 * j;
      exp_acc(0, ii ? 10'h010 : 10'h020, 4'd0, 32'd0, t0 + 1);
      exp_done(0, ii, 1'b1, ii ? 32'h0050_0093 : 32'h1000_0020, t0 + 2);
    end
    tick(16); dren_s[0] = 1'b0; tick(3); iren_s[0] = 1'b0; tick(4);
    chk(iload_w[0] == 32'h0050_0093 && dload_w[0] == 32'h1000_0020, "load_hold",
        $sformatf("iload %h dload %h, expected 00500093 10000020", iload_w[0], dload_w[0]));
    // asynchronous reset in the middle of a latency-2 read
    c = cyc; dren_s[1] = 1'b1; daddr_s[1] = 32'h80;
    exp_acc(1, 10'h020, 4'd0, 32'd0, c + 1);
    tick(1); dren_s[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk(!ram_en_w[1] && ram_we_w[1] == 4'd0 && ram_addr_w[1] == '0 && ram_wdata_w[1] == 32'd0, "async_reset_ram",
        $sformatf("en %0b we %b addr %h wdata %h, expected all 0", ram_en_w[1], ram_we_w[1], ram_addr_w[1], ram_wdata_w[1]));
    chk(iwait_w[1] && dwait_w[1] && iload_w[1] == 32'd0 && dload_w[1] == 32'd0, "async_reset_cpu",
        $sformatf("iwait %0b dwait %0b iload %h dload %h, expected 1 1 0 0", iwait_w[1], dwait_w[1], iload_w[1], dload_w[1]));
    tick(1);
    #2 rst_n = 1'b1;
    tick(2);
    chk(!ram_en_w[1] && iwait_w[1] && dwait_w[1], "post_reset_idle",
        $sformatf("en %0b iwait %0b dwait %0b, expected 0 1 1", ram_en_w[1], iwait_w[1], dwait_w[1]));
    c = cyc; dren_s[1] = 1'b1; daddr_s[1] = 32'h84;
    exp_acc(1, 10'h021, 4'd0, 32'd0, c + 1);
    exp_done(1, 1'b0, 1'b1, 32'h2000_0021, c + 3);
    tick(1); dren_s[1] = 1'b0; tick(5);
    for (int t = 0; t < 20 && (dq.size() != 0 || aq.size() != 0); t++) tick(1);
    chk(dq.size() == 0 && aq.size() == 0, "drain", $sformatf("outstanding done %0d access %0d, expected 0 0", dq.size(), aq.size()));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
Memory controller that implements the ramctrl side of the CPU-RAM interface. It arbitrates the CPU's instruction-fetch and data-access requests onto one single-port, word-wide synchronous SRAM with fixed read latency. It returns fetched/loaded words and holds the CPU in wait until each access completes. It sits directly downstream of the CPU datapath and upstream of the on-chip RAM macro.

Parameters:
ADDR_W, 14, word-address width into the RAM (RAM depth = 2**ADDR_W words)
RAM_LATENCY, 1, cycles from ram_en assertion to valid ram_rdata (legal range 1..4)

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
iren  input  1  instruction read request
dren  input  1  data read request
dwen  input  4  data write byte enables; non-zero means write request
iaddr  input  32  instruction byte address
daddr  input  32  data byte address
dstore  input  32  data write word
iwait  output  1  high = instruction access not complete
dwait  output  1  high = data access not complete
iload  output  32  fetched instruction word
dload  output  32  loaded data word
ram_en  output  1  RAM access strobe
ram_we  output  4  RAM byte write enables
ram_addr  output  ADDR_W  RAM word address
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data, valid RAM_LATENCY cycles after ram_en

Behaviour:
- Reset is asynchronous and active-low on nRST. All state clears on assertion regardless of clock. On reset: FSM=IDLE, iwait=1, dwait=1, iload=0, dload=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Word address = byte address[ADDR_W+1:2]. Bits [1:0] and the upper bits are ignored. No misalignment fault.
- A data request is (dren | (dwen!=0)). If both dren and dwen!=0, the access is a write.
- Priority: data over instruction.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE + data write pending -> WRITE. Latch daddr/dstore/dwen, ram_en=1, ram_we=dwen.
  - IDLE + data read pending -> READ(D). Latch daddr, ram_en=1.
  - IDLE + only iren -> READ(I). Latch iaddr, ram_en=1.
  - IDLE, no request -> stay.
- ram_en/ram_we are registered: high for exactly one cycle, the first cycle of READ/WRITE.
- READ: a down-counter loads RAM_LATENCY-1 on entry. When it reaches 0 and ram_rdata is valid, capture into iload or dload -> DONE.
- WRITE: lasts 1 cycle -> DONE.
- DONE: the granted requester's wait is 0 for exactly this cycle; the other wait stays 1 -> IDLE.
- Read latency from request to wait-low = RAM_LATENCY+1 cycles. Write latency = 2 cycles.
- Back-to-back: IDLE re-arbitrates on the cycle after DONE. A pending iren behind a continuous data stream is served only when no data request is pending (starvation allowed unless the optional feature is enabled).
- iload/dload hold their last captured value until the next completion of the same type.
- Request withdrawn mid-access: the RAM access finishes and is not cancelled. A read still captures, a write still commits. DONE still pulses wait low, and the CPU may ignore it.
- Address/data changes after grant are ignored; the latched values are used.
- wait is 1 in every cycle except the DONE cycle of that port, including when the port is idle.
- Reset mid-access: returns to IDLE immediately. An in-flight RAM write strobe is dropped if not yet issued.

Optional Feature:
RAM_CTRL_FAIR_ARB_EN
- Defined: a 2-bit counter tracks consecutive data grants made while iren was pending. At count 2 the next IDLE arbitration grants the instruction request and clears the counter. The counter also clears on any instruction grant.
- Not defined: strict data-over-instruction priority; the counter logic is absent.

Test Plan:
- Reset: nRST=0 mid-READ with RAM_LATENCY=2 -> all outputs return to reset values asynchronously; after release, FSM=IDLE and ram_en=0.
- Single fetch: RAM word 0x10 = 0x00500093, iren=1, iaddr=0x40, RAM_LATENCY=1 -> ram_en pulse with ram_addr=0x10; iwait=0 on cycle 2 after request with iload=0x00500093; dwait stays 1.
- Byte write then read: dwen=4'b0010, daddr=0x104, dstore=0x0000AB00 -> ram_we=4'b0010 at word 0x41, dwait low at cycle 2; then dren at daddr=0x104 -> dload bits [15:8]=0xAB.
- Simultaneous requests: iren=1 and dren=1 in the same cycle -> data served first (dwait low first); iwait low RAM_LATENCY+2 cycles later.
- Latency sweep: RAM_LATENCY=1..4 -> read completion exactly RAM_LATENCY+1 cycles after request.
- Fairness: with RAM_CTRL_FAIR_ARB_EN defined, dren held high continuously with iren=1 -> grant order D,D,I,D,D,I. Undefined -> iwait never drops while dren is held.
